instr_fetch: RTL and testbench

//  Initiator side of the instruction-memory read interface: owns the PC, drives the

---
 rtl/instr_fetch.sv | 86 ++++++++
 tb/tb_instr_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads the combinational ROM, buffers {pc, instr} toward decode.
// Latency: a word fetched at edge N is presented on out_* after that edge; redirect-to-valid is 2 edges.
// Backpressure: out_ready low fills the buffer and then stalls the PC; a pop frees room the same cycle.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   buf_pc    [FIFO_DEPTH];
  logic [31:0]   buf_instr [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          fetch;

  assign imem_addr = pc;
  assign out_valid = (count != '0);

  // Handshake decode: a pop frees a slot for a fetch in the same cycle; redirect blocks fetch.
  always_comb begin
    pop       = out_valid & out_ready;
    fetch     = !redirect && !halt && ((count < DEPTH_C) || pop);
    out_pc    = '0;
    out_instr = '0;
    if (out_valid) begin
      out_pc    = buf_pc[rd_ptr];
      out_instr = buf_instr[rd_ptr];
    end
  end

  // PC, fetch buffer and status registers; redirect flushes and overrides any pop or push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else if (redirect) begin
      pc           <= {redirect_pc[31:2], 2'b00};
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      misalign_err <= |redirect_pc[1:0];
    end else begin
      misalign_err <= 1'b0;
      if (fetch) begin
        buf_pc[wr_ptr]    <= pc;
        buf_instr[wr_ptr] <= imem_instr;
        wr_ptr            <= wr_ptr + 1'b1;
        pc                <= pc + 32'd4;
        fetch_count       <= fetch_count + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(fetch) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run.
// Reference model is a queue of {pc, instr} entries updated once per clock edge.
// ROM contents: word i holds i + 0x100.
module tb_instr_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int total = 0;
  int bad = 0;

  ent_t        mq[$];
  logic [31:0] mpc;
  logic [31:0] mfc;
  logic        mmis;

  instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  assign imem_instr = rom(imem_addr);

  task automatic model_reset();
    mq.delete();
    mpc  = RPC;
    mfc  = 0;
    mmis = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_step();
    int   sz;
    bit   pop;
    ent_t e;
    sz  = mq.size();
    pop = (sz > 0) && out_ready;
    if (redirect) begin
      mq.delete();
      mpc  = {redirect_pc[31:2], 2'b00};
      mmis = |redirect_pc[1:0];
    end else begin
      mmis = 1'b0;
      if (pop) void'(mq.pop_front());
      if (!halt && (sz < DEPTH || pop)) begin
        e.pc    = mpc;
        e.instr = rom(mpc);
        mq.push_back(e);
        mpc = mpc + 32'd4;
        mfc = mfc + 32'd1;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; halt = 1'b0; out_ready = 1'b0; redirect_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
    total++; if (imem_addr !== RPC) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RPC); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL reset_fcount got=%0d exp=0", fetch_count); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL reset_mis got=%0b exp=0", misalign_err); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%0b exp=1", out_valid); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (out_pc !== 32'(i * 4) || out_instr !== 32'(i + 32'h100)) begin
        bad++; $display("FAIL stream_%0d got=%h/%h exp=%h/%h", i, out_pc, out_instr, i * 4, i + 32'h100);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    repeat (5) step();
    total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL bp_pc got=%h exp=8", imem_addr); end
    total++; if (fetch_count !== 32'd2) begin bad++; $display("FAIL bp_fcount got=%0d exp=2", fetch_count); end
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("FAIL bp_head got=%0b/%h exp=1/0", out_valid, out_pc); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)) begin
        bad++; $display("FAIL bp_drain_%0d got=%0b/%h exp=1/%h", i, out_valid, out_pc, i * 4);
      end
      step();
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_gap got=%0b exp=0", out_valid); end
    step();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'h110) begin
      bad++; $display("FAIL redir_target got=%0b/%h/%h exp=1/40/110", out_valid, out_pc, out_instr);
    end
    step();
    total++; if (out_pc !== 32'h44) begin bad++; $display("FAIL redir_next got=%h exp=44", out_pc); end
  endtask

  task automatic test_misalign();
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
    total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%0b exp=1", misalign_err); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL mis_addr got=%h exp=40", imem_addr); end
    step();
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_clear got=%0b exp=0", misalign_err); end
    total++; if (out_pc !== 32'h40) begin bad++; $display("FAIL mis_target got=%h exp=40", out_pc); end
  endtask

  task automatic test_halt();
    logic [31:0] hpc;
    logic [31:0] hfc;
    out_ready = 1'b0;
    repeat (3) step();
    hpc = mpc; hfc = mfc;
    halt = 1'b1; out_ready = 1'b1;
    repeat (3) step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL halt_drain got=%0b exp=0", out_valid); end
    total++; if (imem_addr !== hpc) begin bad++; $display("FAIL halt_pc got=%h exp=%h", imem_addr, hpc); end
    total++; if (fetch_count !== hfc) begin bad++; $display("FAIL halt_fcount got=%0d exp=%0d", fetch_count, hfc); end
    halt = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || out_pc !== hpc) begin bad++; $display("FAIL halt_resume got=%0b/%h exp=1/%h", out_valid, out_pc, hpc); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0b exp=0", out_valid); end
    total++; if (imem_addr !== RPC) begin bad++; $display("FAIL arst_pc got=%h exp=%h", imem_addr, RPC); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL arst_fcount got=%0d exp=0", fetch_count); end
    @(negedge clk);
    rst_n = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    total++; if (out_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%h exp=fffffffc", out_pc); end
    step();
    total++; if (out_pc !== 32'h0 || out_instr !== 32'h100) begin bad++; $display("FAIL wrap_zero got=%h/%h exp=0/100", out_pc, out_instr); end
  endtask

  task automatic test_random();
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    for (int n = 0; n < 400; n++) begin
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      halt        = ($urandom_range(0, 4) == 0);
      out_ready   = $urandom_range(0, 1) == 1;
      step();
      ev  = (mq.size() != 0);
      epc = ev ? mq[0].pc : 32'h0;
      ein = ev ? mq[0].instr : 32'h0;
      total++;
      if (out_valid !== ev || out_pc !== epc || out_instr !== ein) begin
        bad++; $display("FAIL rand_out_%0d got=%0b/%h/%h exp=%0b/%h/%h", n, out_valid, out_pc, out_instr, ev, epc, ein);
      end
      total++;
      if (imem_addr !== mpc || fetch_count !== mfc || misalign_err !== mmis) begin
        bad++; $display("FAIL rand_state_%0d got=%h/%0d/%0b exp=%h/%0d/%0b", n, imem_addr, fetch_count, misalign_err, mpc, mfc, mmis);
      end
    end
    redirect = 1'b0; halt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_halt();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
